// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (A=fetch, B=data) front end for the external-SRAM bus driver; SRAM_ARB_FIXED_PRIO_EN makes B win ties.
// Latency: grant edge -> m_valid +1, rvalid +3 with m_ready high and m_done one cycle later; zero-mask requests complete at +2.
// Backpressure: one transaction in flight; ports see ready only in IDLE; m_* held stable until m_ready, then wait for m_done.
module sram_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [15:0]   a_wdata,
  input  logic [1:0]    a_bmask,
  output logic          a_rvalid,
  output logic [15:0]   a_rdata,

  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [15:0]   b_wdata,
  input  logic [1:0]    b_bmask,
  output logic          b_rvalid,
  output logic [15:0]   b_rdata,

  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [15:0]   m_wdata,
  output logic [1:0]    m_bmask,
  input  logic          m_done,
  input  logic [15:0]   m_rdata,

  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LOCAL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          grant_a;
  logic          grant_b;
  logic          grant_any;

  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [15:0]   req_wdata;
  logic [1:0]    req_bmask;

  logic          cpl_fire;
  logic [15:0]   cpl_data;

  // Pick a winner in IDLE only; a tie goes to the port that did not win last time
  // (or always to B in the fixed-priority build).
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (a_valid && b_valid) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        grant_b = 1'b1;
`else
        if (owner) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
`endif
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign grant_any = grant_a | grant_b;

  // Select the winning port's request fields for latching on the grant edge.
  always_comb begin
    req_addr  = a_addr;
    req_we    = a_we;
    req_wdata = a_wdata;
    req_bmask = a_bmask;
    if (grant_b) begin
      req_addr  = b_addr;
      req_we    = b_we;
      req_wdata = b_wdata;
      req_bmask = b_bmask;
    end
  end

  // Next-state and Moore/handshake outputs; a zero byte mask never touches the driver.
  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = (state != IDLE);
    cpl_fire  = 1'b0;
    cpl_data  = 16'h0000;
    case (state)
      IDLE: begin
        a_ready = grant_a;
        b_ready = grant_b;
        if (grant_any) begin
          state_nxt = (req_bmask != 2'b00) ? ISSUE : LOCAL;
        end
      end
      ISSUE: begin
        // A stray m_done here is a driver protocol error and is dropped.
        m_valid = 1'b1;
        if (m_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          cpl_fire  = 1'b1;
          cpl_data  = m_rdata;
          state_nxt = IDLE;
        end
      end
      LOCAL: begin
        cpl_fire  = 1'b1;
        cpl_data  = 16'h0000;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transaction on the spot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the granted request and its owner; these only move on a grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_addr  <= '0;
      m_we    <= 1'b0;
      m_wdata <= 16'h0000;
      m_bmask <= 2'b00;
      owner   <= 1'b1;
    end else if (grant_any) begin
      m_addr  <= req_addr;
      m_we    <= req_we;
      m_wdata <= req_wdata;
      m_bmask <= req_bmask;
      owner   <= grant_b;
    end
  end

  // Route the completion to the owning port only; rvalid is a one-cycle pulse,
  // rdata holds until that port's next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= 16'h0000;
      b_rdata  <= 16'h0000;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (cpl_fire) begin
        if (owner) begin
          b_rvalid <= 1'b1;
          b_rdata  <= cpl_data;
        end else begin
          a_rvalid <= 1'b1;
          a_rdata  <= cpl_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed-vector bench for sram_arbiter with hand-computed expectations.
// Latency: inputs change 2 time units after each rising edge; outputs sampled at that point or 1 unit later.
// Backpressure: the bench plays the SRAM driver, holding m_ready low or pulsing m_done as each case needs.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_we, a_rvalid;
  logic [31:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [1:0]  a_bmask;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [31:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [1:0]  b_bmask;
  logic        m_valid, m_ready, m_we, m_done;
  logic [31:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  m_bmask;
  logic        busy, owner;

  int n_checks = 0;
  int n_pass   = 0;

  sram_arbiter #(.AW(32)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_we(a_we),
    .a_wdata(a_wdata), .a_bmask(a_bmask), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_we(b_we),
    .b_wdata(b_wdata), .b_bmask(b_bmask), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_bmask(m_bmask), .m_done(m_done), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a grant, then act as a driver with m_ready high and
  // m_done one cycle after issue; checks owner and the completion.
  task automatic serve(input logic [15:0] rd, output int gnt);
    gnt = -1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (a_ready || b_ready) break;
      step();
    end
    if (!(a_ready || b_ready)) begin
      chk("grant_timeout", 32'd0, 32'd1);
      return;
    end
    gnt = b_ready ? 1 : 0;
    step();
    chk("srv_owner", {31'd0, owner}, gnt);
    chk("srv_issue", {31'd0, m_valid}, 32'd1);
    step();
    m_done  = 1'b1;
    m_rdata = rd;
    step();
    m_done  = 1'b0;
    chk("srv_rvalid", {31'd0, (gnt == 1) ? b_rvalid : a_rvalid}, 32'd1);
    chk("srv_rdata", {16'd0, (gnt == 1) ? b_rdata : a_rdata}, {16'd0, rd});
  endtask

  initial begin
    int g;
    int exp_g;
    reset   = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_we = 1'b0; a_wdata = '0; a_bmask = '0;
    b_valid = 1'b0; b_addr = '0; b_we = 1'b0; b_wdata = '0; b_bmask = '0;
    m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
    repeat (3) step();

    // Reset state
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", {16'd0, b_rdata}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_wdata", {16'd0, m_wdata}, 32'd0);
    chk("rst_m_bmask", {30'd0, m_bmask}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd1);
    reset = 1'b0;
    step();

    // Basic port-A read, latency 3 from accept
    a_valid = 1'b1; a_addr = 32'h0000_1234; a_we = 1'b0; a_bmask = 2'b11;
    m_ready = 1'b1;
    #1;
    chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t1_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    #1;
    chk("t1_a_ready_pulse", {31'd0, a_ready}, 32'd0);
    chk("t1_m_valid", {31'd0, m_valid}, 32'd1);
    chk("t1_m_addr", m_addr, 32'h0000_1234);
    chk("t1_m_bmask", {30'd0, m_bmask}, 32'd3);
    chk("t1_owner", {31'd0, owner}, 32'd0);
    step();
    m_done = 1'b1; m_rdata = 16'hBEEF;
    chk("t1_m_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t1_a_rvalid_early", {31'd0, a_rvalid}, 32'd0);
    step();
    m_done = 1'b0;
    chk("t1_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t1_a_rdata", {16'd0, a_rdata}, 32'h0000_BEEF);
    chk("t1_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    step();
    chk("t1_a_rvalid_pulse", {31'd0, a_rvalid}, 32'd0);
    chk("t1_a_rdata_hold", {16'd0, a_rdata}, 32'h0000_BEEF);

    // Both ports valid continuously: arbitration order
    reset_dut();
    a_valid = 1'b1; a_addr = 32'h0000_0100; a_we = 1'b0; a_bmask = 2'b11;
    b_valid = 1'b1; b_addr = 32'h0000_0200; b_we = 1'b0; b_bmask = 2'b11;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(16'h1000 + 16'(i), g);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_g = 1;
`else
      exp_g = i % 2;
`endif
      chk("t2_grant_order", g, exp_g);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();

    // Port-B write stalled by m_ready low for 5 cycles
    m_ready = 1'b0;
    b_valid = 1'b1; b_addr = 32'h00FF_0002; b_we = 1'b1; b_wdata = 16'h5A5A; b_bmask = 2'b10;
    #1;
    chk("t3_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0; b_wdata = 16'hFFFF; b_bmask = 2'b01; b_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("t3_m_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_m_wdata", {16'd0, m_wdata}, 32'h0000_5A5A);
      chk("t3_m_bmask", {30'd0, m_bmask}, 32'd2);
      chk("t3_m_addr", m_addr, 32'h00FF_0002);
      step();
    end
    chk("t3_m_we", {31'd0, m_we}, 32'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t3_m_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t3_b_rvalid_early", {31'd0, b_rvalid}, 32'd0);
    m_done = 1'b1; m_rdata = 16'h1111;
    step();
    m_done = 1'b0;
    chk("t3_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t3_b_rdata", {16'd0, b_rdata}, 32'h0000_1111);
    chk("t3_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    step();
    chk("t3_b_rvalid_once", {31'd0, b_rvalid}, 32'd0);

    // Zero byte mask: local completion, no driver access
    m_ready = 1'b1;
    a_valid = 1'b1; a_addr = 32'h0000_4000; a_we = 1'b0; a_bmask = 2'b00;
    #1;
    chk("t4_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    chk("t4_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_a_rvalid_early", {31'd0, a_rvalid}, 32'd0);
    step();
    chk("t4_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t4_a_rdata", {16'd0, a_rdata}, 32'd0);
    chk("t4_m_valid_late", {31'd0, m_valid}, 32'd0);
    chk("t4_busy_done", {31'd0, busy}, 32'd0);
    step();
    chk("t4_a_rvalid_pulse", {31'd0, a_rvalid}, 32'd0);

    // Reset while waiting for m_done, then a late m_done
    a_valid = 1'b1; a_addr = 32'h0000_5000; a_bmask = 2'b11;
    step();
    a_valid = 1'b0;
    step();
    chk("t5_busy_wait", {31'd0, busy}, 32'd1);
    chk("t5_m_valid_wait", {31'd0, m_valid}, 32'd0);
    reset = 1'b1;
    step();
    chk("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_owner", {31'd0, owner}, 32'd1);
    chk("t5_rst_b_rdata", {16'd0, b_rdata}, 32'd0);
    reset = 1'b0;
    m_done = 1'b1; m_rdata = 16'hDEAD;
    step();
    m_done = 1'b0;
    chk("t5_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("t5_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    step();
    chk("t5_a_rvalid_late", {31'd0, a_rvalid}, 32'd0);
    chk("t5_a_rdata", {16'd0, a_rdata}, 32'd0);
    a_valid = 1'b1; b_valid = 1'b1; b_bmask = 2'b11; b_we = 1'b0;
    #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    chk("t5_tie_a", {31'd0, a_ready}, 32'd0);
    chk("t5_tie_b", {31'd0, b_ready}, 32'd1);
`else
    chk("t5_tie_a", {31'd0, a_ready}, 32'd1);
    chk("t5_tie_b", {31'd0, b_ready}, 32'd0);
`endif
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    m_done = 1'b1; m_rdata = 16'h7777;
    step();
    m_done = 1'b0;
    step();

    // m_done during ISSUE is ignored
    m_ready = 1'b0;
    b_valid = 1'b1; b_addr = 32'h0000_6000; b_we = 1'b0; b_bmask = 2'b01;
    step();
    b_valid = 1'b0;
    m_done = 1'b1; m_rdata = 16'hBAD0;
    step();
    m_done = 1'b0;
    chk("t6_m_valid", {31'd0, m_valid}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_b_rvalid_issue", {31'd0, b_rvalid}, 32'd0);
    step();
    chk("t6_b_rvalid_issue2", {31'd0, b_rvalid}, 32'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t6_m_valid_drop", {31'd0, m_valid}, 32'd0);
    chk("t6_b_rvalid_wait", {31'd0, b_rvalid}, 32'd0);
    m_done = 1'b1; m_rdata = 16'hC0DE;
    step();
    m_done = 1'b0;
    chk("t6_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t6_b_rdata", {16'd0, b_rdata}, 32'h0000_C0DE);
    step();
    chk("t6_b_rvalid_once", {31'd0, b_rvalid}, 32'd0);
    step();
    chk("t6_b_rvalid_once2", {31'd0, b_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
